script_loader_mem: RTL

Parametrised script memory that assembles UART bytes into WORD_BYTES-wide script words, stores up to DEPTH words, and serves them to the script executor by program counter. It replaces the fixed 16-bit/8-bit-count script memory with these additions:
- configurable word width and depth;
- a trailing XOR checksum;
- overflow detection;
- reload-while-running;
- status outputs.

It sits between the UART receiver (`dataOut_bits`/`dataOut_valid`) and the script-execution FSM (`pc` in, `script` out).

---
 rtl/script_loader_mem_if.sv | 26 ++
 rtl/script_loader_mem.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/script_loader_mem_if.sv
// UART-side byte stream, executor read port and load status of the script memory.
interface script_loader_mem_if #(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned ADDR_W     = 8
) ();
  logic [7:0]              dataOut_bits;
  logic                    dataOut_valid;
  logic [ADDR_W-1:0]       pc;
  logic                    script_mode;
  logic [8*WORD_BYTES-1:0] script;
  logic [7:0]              script_num;
  logic                    load_busy;
  logic                    load_done;
  logic                    cks_err;
  logic                    ovf_err;

  modport master (
    output dataOut_bits, dataOut_valid, pc,
    input  script_mode, script, script_num, load_busy, load_done, cks_err, ovf_err
  );

  modport slave (
    input  dataOut_bits, dataOut_valid, pc,
    output script_mode, script, script_num, load_busy, load_done, cks_err, ovf_err
  );
endinterface

// File: rtl/script_loader_mem.sv
// Script memory loaded from a UART byte frame (count, words MSB first, XOR checksum)
// and read by the script executor through a registered pc-addressed port.
module script_loader_mem #(
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input logic               clock,
  input logic               reset,
  script_loader_mem_if.slave bus
);
  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned BC_W   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CMP_W  = (ADDR_W > 8) ? ADDR_W : 8;
  localparam logic [8:0]  DEPTH9 = 9'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA_RX, CHECK_RX, READY} state_t;

  state_t            state_q, state_d;
  logic              valid_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        xor_q, xor_d;
  logic [8:0]        word_idx_q, word_idx_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              mode_q, mode_d;
  logic [7:0]        num_q, num_d;
  logic              cks_q, cks_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [WORD_W-1:0] script_q;

  logic [WORD_W-1:0] mem [0:DEPTH-1];
  logic              we;
  logic [WORD_W-1:0] assembled;
  logic [7:0]        lim;
  logic              accept;
  logic              rd_hit;

  assign accept    = bus.dataOut_valid & ~valid_q;
  // Cast keeps the low WORD_W bits, so the new byte lands in the LSB and older bytes shift up.
  assign assembled = WORD_W'({asm_q, bus.dataOut_bits});
  assign lim       = ({1'b0, cnt_q} > DEPTH9) ? DEPTH9[7:0] : cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xor_d      = xor_q;
    word_idx_d = word_idx_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    mode_d     = mode_q;
    num_d      = num_q;
    cks_d      = cks_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    we         = 1'b0;
    case (state_q)
      IDLE, READY: begin
        if (accept) begin
          cnt_d      = bus.dataOut_bits;
          xor_d      = bus.dataOut_bits;
          word_idx_d = '0;
          byte_cnt_d = '0;
          mode_d     = 1'b0;
          num_d      = '0;
          cks_d      = 1'b0;
          ovf_d      = 1'b0;
          state_d    = (bus.dataOut_bits == 8'd0) ? CHECK_RX : DATA_RX;
        end
      end
      DATA_RX: begin
        if (accept) begin
          xor_d = xor_q ^ bus.dataOut_bits;
          asm_d = assembled;
          if (byte_cnt_q == BC_W'(WORD_BYTES - 1)) begin
            byte_cnt_d = '0;
            word_idx_d = word_idx_q + 9'd1;
            if (word_idx_q < DEPTH9) we = 1'b1;
            else                     ovf_d = 1'b1;
            if (word_idx_q + 9'd1 == {1'b0, cnt_q}) state_d = CHECK_RX;
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
          end
        end
      end
      CHECK_RX: begin
        if (accept) begin
          done_d  = 1'b1;
          state_d = READY;
          if (bus.dataOut_bits == xor_q) begin
            mode_d = 1'b1;
            num_d  = lim;
          end else begin
            cks_d  = 1'b1;
            mode_d = 1'b0;
            num_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
      xor_q      <= '0;
      word_idx_q <= '0;
      byte_cnt_q <= '0;
      asm_q      <= '0;
      mode_q     <= 1'b0;
      num_q      <= '0;
      cks_q      <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      script_q   <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= bus.dataOut_valid;
      cnt_q      <= cnt_d;
      xor_q      <= xor_d;
      word_idx_q <= word_idx_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      mode_q     <= mode_d;
      num_q      <= num_d;
      cks_q      <= cks_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      script_q   <= rd_hit ? mem[bus.pc[MEM_AW-1:0]] : '0;
    end
  end

  // Storage is deliberately not reset; script_num/script_mode alone gate what is readable.
  always_ff @(posedge clock) begin
    if (we) mem[word_idx_q[MEM_AW-1:0]] <= assembled;
  end

  assign rd_hit = mode_q && (CMP_W'(bus.pc) < CMP_W'(num_q));

  assign bus.script_mode = mode_q;
  assign bus.script      = script_q;
  assign bus.script_num  = num_q;
  assign bus.load_busy   = (state_q == DATA_RX) || (state_q == CHECK_RX);
  assign bus.load_done   = done_q;
  assign bus.cks_err     = cks_q;
  assign bus.ovf_err     = ovf_q;
endmodule
